seg7_udcounter: RTL and testbench

- Parametrised multi-digit up/down counter that drives DIGITS seven-segment displays.
- Successor to the single-digit hex up/down display counter; adds per-digit carry/borrow, a selectable hex or BCD radix, parallel load, clear, wrap flags and registered segment outputs.
- Sits after the debounced/edge-detected button block: up/down/clr/load are one-cycle pulses on CLOCK_50.

---
 rtl/seg7_udcounter.sv | 145 ++++++++++++++
 tb/tb_seg7_udcounter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seg7_udcounter.sv
// Multi-digit hex/BCD up/down counter with per-digit carry/borrow and registered 7-segment outputs.
// Optional leading-zero blanking is enabled by defining SEG7_UDCOUNTER_LZB_EN.
module seg7_udcounter #(
  parameter int DIGITS         = 4,
  parameter int DECIMAL        = 0,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  up,
  input  logic                  down,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  wrap_up,
  output logic                  wrap_dn
);

  localparam logic [3:0] DMAX = (DECIMAL != 0) ? 4'd9 : 4'd15;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1011000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    if (SEG_ACTIVE_LOW == 0) g = ~g;
    return g;
  endfunction

`ifdef SEG7_UDCOUNTER_LZB_EN
  function automatic logic [6:0] blank_seg();
    return (SEG_ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000;
  endfunction
`endif

  // Saturates out-of-range BCD nibbles; identity in hex mode.
  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    if (DECIMAL != 0 && v > 4'd9) return 4'd9;
    return v;
  endfunction

  function automatic logic [7*DIGITS-1:0] decode_all(input logic [4*DIGITS-1:0] c);
    logic [7*DIGITS-1:0] s;
`ifdef SEG7_UDCOUNTER_LZB_EN
    logic zero_above;
    zero_above = 1'b1;
`endif
    s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      s[7*i +: 7] = glyph(c[4*i +: 4]);
`ifdef SEG7_UDCOUNTER_LZB_EN
      zero_above = zero_above && (c[4*i +: 4] == 4'd0);
      if (i > 0 && zero_above) s[7*i +: 7] = blank_seg();
`endif
    end
    return s;
  endfunction

  logic [4*DIGITS-1:0] count_p0;
  logic                wrap_up_p0;
  logic                wrap_dn_p0;
  logic                chain;
  logic [3:0]          dig;
  logic                inc;
  logic                dec;

  assign inc = up & ~down;
  assign dec = down & ~up;

  // Stage p0: command decode and combinational carry/borrow chain
  always_comb begin
    count_p0   = count;
    wrap_up_p0 = 1'b0;
    wrap_dn_p0 = 1'b0;
    chain      = 1'b0;
    dig        = 4'd0;
    if (clr) begin
      count_p0 = '0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++)
        count_p0[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
    end else if (inc) begin
      chain = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        dig = count[4*i +: 4];
        if (chain) begin
          if (dig >= DMAX) begin
            count_p0[4*i +: 4] = 4'd0;
          end else begin
            count_p0[4*i +: 4] = dig + 4'd1;
            chain = 1'b0;
          end
        end
      end
      wrap_up_p0 = chain;
    end else if (dec) begin
      chain = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        dig = count[4*i +: 4];
        if (chain) begin
          if (dig == 4'd0) begin
            count_p0[4*i +: 4] = DMAX;
          end else begin
            count_p0[4*i +: 4] = dig - 4'd1;
            chain = 1'b0;
          end
        end
      end
      wrap_dn_p0 = chain;
    end
  end

  // Stage p1: count, flags and segments registered together from the next-state count
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count   <= '0;
      hex     <= decode_all('0);
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
    end else begin
      count   <= count_p0;
      hex     <= decode_all(count_p0);
      wrap_up <= wrap_up_p0;
      wrap_dn <= wrap_dn_p0;
    end
  end

endmodule

// File: tb/tb_seg7_udcounter.sv
// Bench for seg7_udcounter: a hex and a BCD instance share stimulus and are compared against integer models.
module tb_seg7_udcounter;

  logic        CLOCK_50 = 1'b0;
  logic        reset, up, down, clr, load;
  logic [15:0] load_val;
  logic [15:0] count_h, count_b;
  logic [27:0] hex_h, hex_b;
  logic        wrap_up_h, wrap_dn_h, wrap_up_b, wrap_dn_b;

  int errors = 0;
  int checks = 0;

  // Reference state: plain integers, counted modulo 16^4 or 10^4.
  int hv, bv;
  logic ewu_h, ewd_h, ewu_b, ewd_b;

  logic [6:0] glyphs [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #10 CLOCK_50 = ~CLOCK_50;

  seg7_udcounter #(.DIGITS(4), .DECIMAL(0), .SEG_ACTIVE_LOW(1)) dut_h (
    .CLOCK_50(CLOCK_50), .reset(reset), .up(up), .down(down), .clr(clr), .load(load),
    .load_val(load_val), .count(count_h), .hex(hex_h), .wrap_up(wrap_up_h), .wrap_dn(wrap_dn_h));

  seg7_udcounter #(.DIGITS(4), .DECIMAL(1), .SEG_ACTIVE_LOW(1)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .up(up), .down(down), .clr(clr), .load(load),
    .load_val(load_val), .count(count_b), .hex(hex_b), .wrap_up(wrap_up_b), .wrap_dn(wrap_dn_b));

  function automatic logic [15:0] nibbles(input int v, input int base);
    logic [15:0] r = '0;
    int p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % base);
      p = p * base;
    end
    return r;
  endfunction

  function automatic logic [27:0] segs(input int v, input int base);
    logic [27:0] s = '0;
    int p = 1;
    for (int i = 0; i < 4; i++) begin
      s[7*i +: 7] = glyphs[(v / p) % base];
`ifdef SEG7_UDCOUNTER_LZB_EN
      if (i > 0 && v < p) s[7*i +: 7] = 7'b1111111;
`endif
      p = p * base;
    end
    return s;
  endfunction

  function automatic int bcd_load(input logic [15:0] lv);
    int r = 0;
    int p = 1;
    int n;
    for (int i = 0; i < 4; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      r = r + n * p;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic u, input logic d, input logic c,
                      input logic l, input logic [15:0] lv);
    reset = r; up = u; down = d; clr = c; load = l; load_val = lv;
    @(posedge CLOCK_50);
    ewu_h = 1'b0; ewd_h = 1'b0; ewu_b = 1'b0; ewd_b = 1'b0;
    if (r || c) begin
      hv = 0; bv = 0;
    end else if (l) begin
      hv = int'(lv); bv = bcd_load(lv);
    end else if (u && !d) begin
      ewu_h = (hv == 65535); hv = (hv + 1) % 65536;
      ewu_b = (bv == 9999);  bv = (bv + 1) % 10000;
    end else if (d && !u) begin
      ewd_h = (hv == 0); hv = (hv + 65535) % 65536;
      ewd_b = (bv == 0); bv = (bv + 9999) % 10000;
    end
    @(negedge CLOCK_50);
    check("hex_count",  32'(count_h),   32'(nibbles(hv, 16)));
    check("hex_seg",    32'(hex_h),     32'(segs(hv, 16)));
    check("hex_wrapup", 32'(wrap_up_h), 32'(ewu_h));
    check("hex_wrapdn", 32'(wrap_dn_h), 32'(ewd_h));
    check("bcd_count",  32'(count_b),   32'(nibbles(bv, 10)));
    check("bcd_seg",    32'(hex_b),     32'(segs(bv, 10)));
    check("bcd_wrapup", 32'(wrap_up_b), 32'(ewu_b));
    check("bcd_wrapdn", 32'(wrap_dn_b), 32'(ewd_b));
    reset = 0; up = 0; down = 0; clr = 0; load = 0;
  endtask

  initial begin
    logic [15:0] lv;
    reset = 1; up = 0; down = 0; clr = 0; load = 0; load_val = '0;
    hv = 0; bv = 0;
    step(1, 0, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 0, 16'h0000);
    // carry chain (BCD copy clamps to 0099)
    step(0, 0, 0, 0, 1, 16'h00FF);
    step(0, 1, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 1, 16'h00AF);
    step(0, 0, 0, 0, 0, 16'h0000);
    // wrap up then down, with an idle cycle after each to see the pulse drop
    step(0, 0, 0, 0, 1, 16'hFFFF);
    step(0, 1, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 0, 16'h0000);
    step(0, 0, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 0, 16'h0000);
    // collisions and priority
    step(0, 0, 0, 0, 1, 16'h0005);
    step(0, 1, 1, 0, 0, 16'h0000);
    step(0, 1, 0, 1, 1, 16'h1234);
    step(0, 0, 0, 0, 1, 16'h1234);
    step(1, 0, 0, 0, 1, 16'h5678);
    // leading-zero patterns
    step(0, 0, 0, 0, 1, 16'h0042);
    step(0, 0, 0, 0, 1, 16'h0000);
    step(0, 0, 0, 0, 1, 16'h0900);
    // randomized traffic, biased towards boundary loads
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: lv = 16'hFFFF;
        1: lv = 16'h0000;
        2: lv = 16'h9999;
        3: lv = 16'h0009;
        default: lv = 16'($urandom);
      endcase
      step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0), lv);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
